// File: rtl/clint_pkg.sv
// Shared offsets, reset values, decode record and byte-strobe merge for the CLINT timer.
package clint_pkg;

  localparam logic [15:0] MSIP_BASE      = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE  = 16'h4000;
  localparam logic [15:0] MTIME_LO       = 16'hBFF8;
  localparam logic [15:0] MTIME_HI       = 16'hBFFC;
  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  // One-hot register class plus hart index for the current APB address
  typedef struct packed {
    logic       err;
    logic       msip;
    logic       cmp_lo;
    logic       cmp_hi;
    logic       mt_lo;
    logic       mt_hi;
    logic [6:0] idx;
  } apb_dec_t;

  // Replace only the bytes whose strobe is set
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/clint_cmp_ch.sv
// One hart channel: mtimecmp, msip bit and the registered timer comparator.
module clint_cmp_ch
  import clint_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] mtime_next,
  input  logic        wr_msip,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [63:0] mtimecmp,
  output logic        msip,
  output logic        mtimer_int
);

  logic [63:0] cmp_next;

  // Next mtimecmp; the comparator sees it on the same edge it is written
  always_comb begin
    cmp_next = mtimecmp;
    if (wr_lo) cmp_next[31:0]  = apply_wstrb(mtimecmp[31:0],  wdata, wstrb);
    if (wr_hi) cmp_next[63:32] = apply_wstrb(mtimecmp[63:32], wdata, wstrb);
  end

  // Channel state and registered compare against next-cycle mtime
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtimecmp   <= MTIMECMP_RESET;
      msip       <= 1'b0;
      mtimer_int <= 1'b0;
    end else begin
      mtimecmp   <= cmp_next;
      if (wr_msip && wstrb[0]) msip <= wdata[0];
      mtimer_int <= (mtime_next >= cmp_next);
    end
  end

endmodule

// File: rtl/clint_timer.sv
// CLINT-style machine timer: prescaled 64-bit mtime, per-hart compare/msip, APB access.
module clint_timer
  import clint_pkg::*;
#(
  parameter int N_HARTS  = 1,
  parameter int PRESCALE = 1,
  parameter int ADDR_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_en,
  input  logic               psel,
  input  logic               penable,
  output logic               pready,
  input  logic [31:0]        paddr,
  input  logic               pwrite,
  input  logic [31:0]        pwdata,
  input  logic [3:0]         pwstrb,
  output logic [31:0]        prdata,
  output logic               pslverr,
  output logic [63:0]        mtime,
  output logic [N_HARTS-1:0] mtimer_int,
  output logic [N_HARTS-1:0] msip_int
);

  localparam int            PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX  = PW'(PRESCALE - 1);
  localparam logic [31:0]   AMASK = (ADDR_W >= 32) ? 32'hFFFF_FFFF
                                                   : 32'((64'd1 << ADDR_W) - 64'd1);

  logic [PW-1:0]             pcnt;
  logic                      tick;
  logic                      acc;
  logic                      wr;
  logic [31:0]               off;
  logic [31:0]               hidx;
  logic                      hart_reg;
  logic [31:0]               rdata;
  logic [63:0]               mtime_next;
  apb_dec_t                  dec;
  logic [N_HARTS-1:0][63:0]  cmp;

  assign acc  = psel & penable;
  assign off  = paddr & AMASK;
  assign wr   = acc & pwrite & ~dec.err;
  assign tick = tick_en & (pcnt == PMAX);

  // Address decode: classify the offset and range-check the hart index
  always_comb begin
    dec      = '0;
    hidx     = '0;
    hart_reg = 1'b0;
    if (off[1:0] != 2'b00) begin
      dec.err = 1'b1;
    end else if (off < 32'(MTIMECMP_BASE)) begin
      hidx     = (off - 32'(MSIP_BASE)) >> 2;
      hart_reg = 1'b1;
      dec.msip = 1'b1;
    end else if (off < 32'(MTIME_LO)) begin
      hidx       = (off - 32'(MTIMECMP_BASE)) >> 3;
      hart_reg   = 1'b1;
      dec.cmp_hi = off[2];
      dec.cmp_lo = ~off[2];
    end else if (off == 32'(MTIME_LO)) begin
      dec.mt_lo = 1'b1;
    end else if (off == 32'(MTIME_HI)) begin
      dec.mt_hi = 1'b1;
    end else begin
      dec.err = 1'b1;
    end
    if (hart_reg && hidx >= 32'(N_HARTS)) begin
      dec.err    = 1'b1;
      dec.msip   = 1'b0;
      dec.cmp_lo = 1'b0;
      dec.cmp_hi = 1'b0;
    end
    dec.idx = hidx[6:0];
  end

  // Next mtime: an APB write to either half wins over the tick
  always_comb begin
    mtime_next = mtime;
    if (wr && dec.mt_lo)      mtime_next[31:0]  = apply_wstrb(mtime[31:0],  pwdata, pwstrb);
    else if (wr && dec.mt_hi) mtime_next[63:32] = apply_wstrb(mtime[63:32], pwdata, pwstrb);
    else if (tick)            mtime_next        = mtime + 64'd1;
  end

  // Prescaler and mtime; both freeze while tick_en is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt  <= '0;
      mtime <= '0;
    end else begin
      mtime <= mtime_next;
      if (tick_en) pcnt <= tick ? '0 : pcnt + PW'(1);
    end
  end

  for (genvar h = 0; h < N_HARTS; h++) begin : g_ch
    clint_cmp_ch u_ch (
      .clk        (clk),
      .rst        (rst),
      .mtime_next (mtime_next),
      .wr_msip    (wr & dec.msip   & (dec.idx == 7'(h))),
      .wr_lo      (wr & dec.cmp_lo & (dec.idx == 7'(h))),
      .wr_hi      (wr & dec.cmp_hi & (dec.idx == 7'(h))),
      .wdata      (pwdata),
      .wstrb      (pwstrb),
      .mtimecmp   (cmp[h]),
      .msip       (msip_int[h]),
      .mtimer_int (mtimer_int[h])
    );
  end

  // Read mux over the decoded register
  always_comb begin
    rdata = '0;
    if (dec.mt_lo) rdata = mtime[31:0];
    if (dec.mt_hi) rdata = mtime[63:32];
    for (int h = 0; h < N_HARTS; h++) begin
      if (dec.idx == 7'(h)) begin
        if (dec.msip)   rdata = {31'b0, msip_int[h]};
        if (dec.cmp_lo) rdata = cmp[h][31:0];
        if (dec.cmp_hi) rdata = cmp[h][63:32];
      end
    end
  end

  assign pready  = acc & ~rst;
  assign pslverr = acc & ~rst & dec.err;
  assign prdata  = (acc & ~rst & ~dec.err) ? rdata : 32'h0;

endmodule

// File: tb/tb_clint_timer.sv
// Randomized and directed check of two clint_timer instances (PRESCALE 1 and 4) against a model.
module tb_clint_timer;

  localparam int NH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_en = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pwstrb = '0;

  logic          pready [2];
  logic          pslverr[2];
  logic [31:0]   prdata [2];
  logic [63:0]   mtime  [2];
  logic [NH-1:0] tint   [2];
  logic [NH-1:0] sint   [2];

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int              ps[2] = '{1, 4};
  logic [63:0]     m_time[2];
  longint unsigned m_en[2];
  logic [63:0]     m_cmp[NH];
  logic [NH-1:0]   m_sip;
  logic [NH-1:0]   m_tint[2];
  logic [31:0]     last_rd[2];
  logic            last_err[2];

  always #5 clk = ~clk;

  clint_timer #(.N_HARTS(NH), .PRESCALE(1), .ADDR_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .tick_en(tick_en), .psel(psel), .penable(penable),
    .pready(pready[0]), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .pwstrb(pwstrb), .prdata(prdata[0]), .pslverr(pslverr[0]), .mtime(mtime[0]),
    .mtimer_int(tint[0]), .msip_int(sint[0]));

  clint_timer #(.N_HARTS(NH), .PRESCALE(4), .ADDR_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .tick_en(tick_en), .psel(psel), .penable(penable),
    .pready(pready[1]), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .pwstrb(pwstrb), .prdata(prdata[1]), .pslverr(pslverr[1]), .mtime(mtime[1]),
    .mtimer_int(tint[1]), .msip_int(sint[1]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                        input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (w & m);
  endfunction

  // 0 error, 1 msip, 2 cmp lo, 3 cmp hi, 4 mtime lo, 5 mtime hi
  function automatic int m_kind(input logic [31:0] a, output int hart);
    int o;
    o    = int'(a & 32'hFFFF);
    hart = 0;
    if (o % 4 != 0)   return 0;
    if (o == 'hBFF8)  return 4;
    if (o == 'hBFFC)  return 5;
    if (o < 'h4000) begin
      hart = o / 4;
      return (hart < NH) ? 1 : 0;
    end
    if (o < 'hBFF8) begin
      hart = (o - 'h4000) / 8;
      if (hart >= NH) return 0;
      return (o % 8 == 0) ? 2 : 3;
    end
    return 0;
  endfunction

  function automatic logic [31:0] m_read(input int k, input int kind, input int h);
    case (kind)
      1: return {31'b0, m_sip[h]};
      2: return m_cmp[h][31:0];
      3: return m_cmp[h][63:32];
      4: return m_time[k][31:0];
      5: return m_time[k][63:32];
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_time[k] = '0;
      m_en[k]   = 0;
      m_tint[k] = '0;
    end
    for (int h = 0; h < NH; h++) m_cmp[h] = 64'hFFFF_FFFF_FFFF_FFFF;
    m_sip = '0;
  endtask

  // state change at a clock edge given the inputs present before it
  task automatic m_edge(input bit wr, input int kind, input int h);
    bit tk;
    if (wr) begin
      if (kind == 1 && pwstrb[0]) m_sip[h] = pwdata[0];
      if (kind == 2) m_cmp[h][31:0]  = merge(m_cmp[h][31:0],  pwdata, pwstrb);
      if (kind == 3) m_cmp[h][63:32] = merge(m_cmp[h][63:32], pwdata, pwstrb);
    end
    for (int k = 0; k < 2; k++) begin
      tk = tick_en && (m_en[k] % longint'(ps[k]) == longint'(ps[k] - 1));
      if (tick_en) m_en[k]++;
      if (wr && kind == 4)      m_time[k][31:0]  = merge(m_time[k][31:0],  pwdata, pwstrb);
      else if (wr && kind == 5) m_time[k][63:32] = merge(m_time[k][63:32], pwdata, pwstrb);
      else if (tk)              m_time[k] = m_time[k] + 64'd1;
      for (int j = 0; j < NH; j++) m_tint[k][j] = (m_time[k] >= m_cmp[j]);
    end
  endtask

  // one clock: check every output against the model, then advance the model
  task automatic step();
    int  kind, h;
    bit  acc;
    logic [31:0] exp_rd;
    #1;
    acc  = psel && penable;
    kind = m_kind(paddr, h);
    for (int k = 0; k < 2; k++) begin
      exp_rd = (acc && kind != 0) ? m_read(k, kind, h) : 32'h0;
      chk($sformatf("pready%0d", k),  pready[k],  acc);
      chk($sformatf("pslverr%0d", k), pslverr[k], acc && kind == 0);
      chk($sformatf("prdata%0d", k),  prdata[k],  exp_rd);
      chk($sformatf("mtime%0d", k),   mtime[k],   m_time[k]);
      chk($sformatf("mtimer_int%0d", k), tint[k], m_tint[k]);
      chk($sformatf("msip_int%0d", k),   sint[k], m_sip);
      if (acc) begin
        last_rd[k]  = prdata[k];
        last_err[k] = pslverr[k];
      end
    end
    @(posedge clk);
    m_edge(acc && pwrite && kind != 0, kind, h);
    @(negedge clk);
  endtask

  task automatic apb(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pwstrb = s;
    step();
    penable = 1'b1;
    step();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  localparam int NPOOL = 14;
  logic [31:0] pool[NPOOL] = '{32'h0, 32'h4, 32'h8, 32'h4000, 32'h4004, 32'h4008,
                               32'h400C, 32'h4010, 32'hBFF8, 32'hBFFC, 32'h5000,
                               32'h4002, 32'hC000, 32'h0001_4000};

  initial begin
    logic [31:0] a, d;
    m_reset();
    // reset state, with an access pending to show pready/prdata gating
    @(negedge clk);
    psel = 1'b1; penable = 1'b1; paddr = 32'hBFF8;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_pready",  pready[k],  1'b0);
      chk("rst_pslverr", pslverr[k], 1'b0);
      chk("rst_prdata",  prdata[k],  32'h0);
      chk("rst_mtime",   mtime[k],   64'h0);
      chk("rst_tint",    tint[k],    '0);
      chk("rst_sint",    sint[k],    '0);
    end
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick_en = 1'b1;

    repeat (10) step();
    chk("mtime_10clk", mtime[0], 64'd10);
    repeat (10) step();
    chk("mtime_20clk_p4", mtime[1], 64'd5);
    repeat (2) step();
    tick_en = 1'b0;
    repeat (8) step();
    chk("freeze_p4", mtime[1], 64'd5);
    tick_en = 1'b1;
    step();
    chk("held_cnt_no_tick", mtime[1], 64'd5);
    step();
    chk("held_cnt_tick", mtime[1], 64'd6);

    apb(1'b0, 32'h4000, 32'h0, 4'h0);
    chk("rd_cmp_lo", last_rd[0], 32'hFFFF_FFFF);
    chk("rd_cmp_lo_err", last_err[0], 1'b0);
    apb(1'b0, 32'h4004, 32'h0, 4'h0);
    chk("rd_cmp_hi", last_rd[0], 32'hFFFF_FFFF);

    // compare against 0x20 while counting
    apb(1'b1, 32'h4004, 32'h0, 4'hF);
    apb(1'b1, 32'h4000, 32'h20, 4'hF);
    repeat (8) step();
    chk("tint_set", tint[0][0], 1'b1);
    chk("tint_p4_clr", tint[1][0], 1'b0);
    apb(1'b1, 32'h4004, 32'h1, 4'hF);
    chk("tint_drop", tint[0][0], 1'b0);

    // full wrap and lo->hi carry
    tick_en = 1'b0;
    apb(1'b1, 32'hBFF8, 32'hFFFF_FFFF, 4'hF);
    apb(1'b1, 32'hBFFC, 32'hFFFF_FFFF, 4'hF);
    chk("mtime_allf", mtime[0], 64'hFFFF_FFFF_FFFF_FFFF);
    tick_en = 1'b1;
    step();
    chk("mtime_wrap", mtime[0], 64'h0);
    tick_en = 1'b0;
    apb(1'b1, 32'hBFFC, 32'h0, 4'hF);
    apb(1'b1, 32'hBFF8, 32'hFFFF_FFFF, 4'hF);
    tick_en = 1'b1;
    step();
    chk("mtime_carry", mtime[0], 64'h1_0000_0000);

    // msip with byte strobes
    apb(1'b1, 32'h4, 32'h1, 4'b0001);
    chk("msip1_set", sint[0], 2'b10);
    apb(1'b1, 32'h4, 32'h0, 4'b0010);
    chk("msip1_keep", sint[0], 2'b10);
    apb(1'b0, 32'h4, 32'h0, 4'h0);
    chk("msip1_rd", last_rd[0], 32'h1);

    // error accesses
    apb(1'b1, 32'h8, 32'hFFFF_FFFF, 4'hF);
    chk("err_hart_slverr", last_err[0], 1'b1);
    chk("err_hart_rd", last_rd[0], 32'h0);
    chk("err_hart_nowr", sint[0], 2'b10);
    apb(1'b1, 32'h5000, 32'h0, 4'hF);
    chk("err_5000", last_err[0], 1'b1);
    apb(1'b1, 32'h4002, 32'h0, 4'hF);
    chk("err_misalign", last_err[0], 1'b1);
    chk("err_cmp_kept", m_cmp[0], 64'h1_0000_0020);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      a = pool[$urandom_range(0, NPOOL - 1)];
      case ($urandom_range(0, 3))
        0: d = $urandom;
        1: d = 32'h0;
        2: d = 32'hFFFF_FFFF;
        default: d = m_time[0][31:0] + 32'($urandom_range(0, 12));
      endcase
      tick_en = ($urandom_range(0, 4) != 0);
      apb($urandom_range(0, 1) == 1, a, d, 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) step();
    end

    // reset in the middle of an access phase aborts the write
    tick_en = 1'b1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h1; pwstrb = 4'hF;
    step();
    penable = 1'b1;
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_pready", pready[0], 1'b0);
    chk("mid_rst_prdata", prdata[0], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    m_reset();
    #1;
    chk("mid_rst_msip", sint[0], 2'b00);
    chk("mid_rst_mtime", mtime[0], 64'h0);
    @(negedge clk);
    m_edge(1'b0, 0, 0);
    repeat (4) step();
    apb(1'b0, 32'h4000, 32'h0, 4'h0);
    chk("mid_rst_cmp", last_rd[0], 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
